sram_port_arbiter: RTL and testbench
====================================

SRAM_PORT_ARBITER -- requirements
Module: sram_port_arbiter

Interface
REQ-001 Parameter WORD_SIZE, default 8, SHALL set the data width of every data port.
REQ-002 Parameter ADDR_SIZE, default 8, SHALL set the address width (256-word SRAM).
REQ-003 Parameter STARVE_MAX, default 4, SHALL set the maximum consecutive port-0 grants while port 1 waits.
REQ-004 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005 rst  input  1  SHALL be the synchronous, active-high reset.
REQ-006 req0/req1  input  1 each  SHALL be the access requests (port 0 = processor, port 1 = loader/debug).
REQ-007 we0/we1  input  1 each  SHALL select write (1) or read (0) for the matching port.
REQ-008 addr0/addr1  input  ADDR_SIZE each  SHALL be the access addresses.
REQ-009 wdata0/wdata1  input  WORD_SIZE each  SHALL be the write data.
REQ-010 gnt0/gnt1  output  1 each  SHALL be the combinational accept signals; a transfer occurs on an edge where reqX and gntX are both 1.
REQ-011 rvalid0/rvalid1  output  1 each  SHALL flag read data for the matching port.
REQ-012 rdata  output  WORD_SIZE  SHALL carry read data, shared by both ports and qualified by rvalidX.
REQ-013 mem_en, mem_we  output  1 each  SHALL be the registered SRAM strobes.
REQ-014 mem_addr  output  ADDR_SIZE  SHALL be the registered SRAM address.
REQ-015 mem_wdata  output  WORD_SIZE  SHALL be the registered SRAM write data.
REQ-016 mem_rdata  input  WORD_SIZE  SHALL be the SRAM read data, valid the cycle after mem_en=1, mem_we=0.

Function
REQ-017 gnt0 and gnt1 SHALL never both be 1; gntX SHALL be 0 when reqX is 0.
REQ-018 With only one request high, that port SHALL be granted in the same cycle.
REQ-019 With both requests high, port 0 SHALL be granted unless starve_cnt equals STARVE_MAX, in which case port 1 SHALL be granted.
REQ-020 starve_cnt SHALL increment (saturating at STARVE_MAX) on each port-0 transfer while req1 is 1, and SHALL clear on any port-1 transfer or any cycle with req1 = 0.
REQ-021 A transfer in cycle N SHALL drive mem_en=1, with mem_we, mem_addr and mem_wdata from the granted port, in cycle N+1.
REQ-022 In a cycle following no transfer, mem_en and mem_we SHALL be 0, and mem_addr and mem_wdata SHALL hold their last values.
REQ-023 A read transfer in cycle N SHALL assert rvalidX for exactly one cycle in N+2, with rdata = mem_rdata.
REQ-024 Write transfers SHALL produce no rvalid.
REQ-025 Throughput SHALL be one transfer per cycle, and back-to-back transfers from either port SHALL be accepted.
REQ-026 Read responses SHALL return in issue order, tagged to the issuing port through a 2-stage port/read pipeline.
REQ-027 After a transfer, a requester SHALL be free to change addr, we and wdata, or drop req, in the next cycle.

Reset
REQ-028 While rst = 1 at an edge, the block SHALL clear mem_en, mem_we, mem_addr, mem_wdata, rdata-tag pipeline, rvalid0, rvalid1 and starve_cnt to 0.
REQ-029 While rst = 1, gnt0 and gnt1 SHALL be forced to 0.
REQ-030 Reads in flight when rst asserts SHALL produce no rvalid after reset.
REQ-031 The first grant SHALL be possible in the first cycle with rst = 0.

Verification
REQ-032 Single write then read, port 0: write addr 130 with data 0x02 in cycle N, read addr 130 in cycle N+1 -> mem_we=1 in N+1, rvalid0=1 and rdata=0x02 in N+3.
REQ-033 Contention: req0 and req1 held high continuously -> grant sequence 0,0,0,0,1,0,0,0,0,1 with STARVE_MAX=4.
REQ-034 Port 1 alone, reads of 128 and 129 back-to-back (memory holds 6, 1) -> rvalid1 on two consecutive cycles, rdata 6 then 1, rvalid0 never asserted.
REQ-035 Interleaved reads from ports 0 and 1 -> each rvalid lands on the issuing port in issue order, and rvalid0 and rvalid1 are never both 1.
REQ-036 rst asserted one cycle after a read transfer -> no rvalid, all outputs 0, starve_cnt 0; the next request after release is granted immediately.
REQ-037 Idle bus (no requests for 3 cycles) -> mem_en=0 and mem_we=0 throughout, with mem_addr unchanged.

Source files
------------

// File: rtl/sram_port_arbiter.sv
// Two-port arbiter in front of a single-port synchronous SRAM: port 0 has priority,
// port 1 is guaranteed a slot after STARVE_MAX consecutive port-0 wins.
module sram_port_arbiter #(
  parameter int WORD_SIZE  = 8,
  parameter int ADDR_SIZE  = 8,
  parameter int STARVE_MAX = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req0,
  input  logic                 req1,
  input  logic                 we0,
  input  logic                 we1,
  input  logic [ADDR_SIZE-1:0] addr0,
  input  logic [ADDR_SIZE-1:0] addr1,
  input  logic [WORD_SIZE-1:0] wdata0,
  input  logic [WORD_SIZE-1:0] wdata1,
  output logic                 gnt0,
  output logic                 gnt1,
  output logic                 rvalid0,
  output logic                 rvalid1,
  output logic [WORD_SIZE-1:0] rdata,
  output logic                 mem_en,
  output logic                 mem_we,
  output logic [ADDR_SIZE-1:0] mem_addr,
  output logic [WORD_SIZE-1:0] mem_wdata,
  input  logic [WORD_SIZE-1:0] mem_rdata
);

  // One spare code keeps the counter at least one bit wide even for STARVE_MAX = 0.
  localparam int CW = $clog2(STARVE_MAX + 2);

  logic [CW-1:0]        starve_cnt;
  logic                 starved;
  logic                 xfer0, xfer1, xfer;
  logic                 sel_we;
  logic [ADDR_SIZE-1:0] sel_addr;
  logic [WORD_SIZE-1:0] sel_wdata;
  logic                 rd_s1;
  logic                 port_s1;

  assign starved = (starve_cnt == CW'(STARVE_MAX));

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!rst) begin
      if (req1 && (!req0 || starved)) gnt1 = 1'b1;
      else if (req0)                  gnt0 = 1'b1;
    end
  end

  assign xfer0 = req0 & gnt0;
  assign xfer1 = req1 & gnt1;
  assign xfer  = xfer0 | xfer1;

  assign sel_we    = xfer1 ? we1    : we0;
  assign sel_addr  = xfer1 ? addr1  : addr0;
  assign sel_wdata = xfer1 ? wdata1 : wdata0;

  // The SRAM returns data one cycle after the strobe, which lines up with rvalid.
  assign rdata = mem_rdata;

  // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      rd_s1      <= 1'b0;
      port_s1    <= 1'b0;
      rvalid0    <= 1'b0;
      rvalid1    <= 1'b0;
      starve_cnt <= '0;
    end else begin
      mem_en  <= xfer;
      mem_we  <= xfer & sel_we;
      if (xfer) begin
        mem_addr  <= sel_addr;
        mem_wdata <= sel_wdata;
      end

      // Read tag travels with the strobe, then becomes the per-port valid.
      rd_s1   <= xfer & ~sel_we;
      port_s1 <= xfer1;
      rvalid0 <= rd_s1 & ~port_s1;
      rvalid1 <= rd_s1 &  port_s1;

      if (!req1 || xfer1)          starve_cnt <= '0;
      else if (xfer0 && !starved)  starve_cnt <= starve_cnt + CW'(1);
    end
  end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed plus randomized bench for sram_port_arbiter against a transaction-level
// model: a shadow memory and a queue of expected read responses with due cycles.
module tb_sram_port_arbiter;

  localparam int W    = 8;
  localparam int A    = 8;
  localparam int SMAX = 4;

  typedef struct packed {
    logic         req;
    logic         we;
    logic [A-1:0] addr;
    logic [W-1:0] wdata;
  } preq_t;

  typedef struct {
    int           port;
    logic [W-1:0] data;
    int           due;
  } rd_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         req0, req1, we0, we1;
  logic [A-1:0] addr0, addr1;
  logic [W-1:0] wdata0, wdata1;
  logic         gnt0, gnt1, rvalid0, rvalid1;
  logic [W-1:0] rdata;
  logic         mem_en, mem_we;
  logic [A-1:0] mem_addr;
  logic [W-1:0] mem_wdata;
  logic [W-1:0] mem_rdata;

  always #5 clk = ~clk;

  sram_port_arbiter #(.WORD_SIZE(W), .ADDR_SIZE(A), .STARVE_MAX(SMAX)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1), .rdata(rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  // Synchronous SRAM, read data valid the cycle after the strobe.
  logic [W-1:0] sram [256];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) sram[mem_addr] <= mem_wdata;
      else        mem_rdata      <= sram[mem_addr];
    end
  end

  // Reference model state
  logic [W-1:0] shadow [256];
  rd_t          pend [$];
  int           starve;
  logic         exp_en, exp_we;
  logic [A-1:0] exp_addr;
  logic [W-1:0] exp_wdata;
  int           cyc;
  int           checks, failures;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  function automatic preq_t rd(input int a);
    return '{req: 1'b1, we: 1'b0, addr: A'(a), wdata: W'($urandom)};
  endfunction

  function automatic preq_t wr(input int a, input int d);
    return '{req: 1'b1, we: 1'b1, addr: A'(a), wdata: W'(d)};
  endfunction

  function automatic preq_t none();
    return '{req: 1'b0, we: 1'b0, addr: A'($urandom), wdata: W'($urandom)};
  endfunction

  // One clock cycle: check registered outputs, drive inputs, check grants, advance model.
  task automatic step(input logic rs, input preq_t p0, input preq_t p1,
                      output logic og0, output logic og1);
    logic e_rv0, e_rv1, eg0, eg1;
    logic [W-1:0] e_rd;
    @(negedge clk);
    check("mem_en", mem_en, exp_en);
    check("mem_we", mem_we, exp_we);
    check("mem_addr", mem_addr, exp_addr);
    check("mem_wdata", mem_wdata, exp_wdata);
    e_rv0 = 1'b0; e_rv1 = 1'b0; e_rd = '0;
    if (pend.size() > 0 && pend[0].due == cyc) begin
      e_rv0 = (pend[0].port == 0);
      e_rv1 = (pend[0].port == 1);
      e_rd  = pend[0].data;
      void'(pend.pop_front());
    end
    check("rvalid0", rvalid0, e_rv0);
    check("rvalid1", rvalid1, e_rv1);
    check("rvalid_excl", rvalid0 & rvalid1, 1'b0);
    if (e_rv0 || e_rv1) check("rdata", rdata, e_rd);

    rst = rs;
    req0 = p0.req; we0 = p0.we; addr0 = p0.addr; wdata0 = p0.wdata;
    req1 = p1.req; we1 = p1.we; addr1 = p1.addr; wdata1 = p1.wdata;
    #1;
    eg1 = !rs && p1.req && (!p0.req || starve == SMAX);
    eg0 = !rs && p0.req && !eg1;
    check("gnt0", gnt0, eg0);
    check("gnt1", gnt1, eg1);
    og0 = gnt0;
    og1 = gnt1;

    @(posedge clk);
    if (rs) begin
      exp_en = 1'b0; exp_we = 1'b0; exp_addr = '0; exp_wdata = '0;
      starve = 0;
      pend.delete();
    end else begin
      exp_en = eg0 | eg1;
      exp_we = 1'b0;
      if (eg0 || eg1) begin
        preq_t p;
        p = eg1 ? p1 : p0;
        exp_we    = p.we;
        exp_addr  = p.addr;
        exp_wdata = p.wdata;
        if (p.we) shadow[p.addr] = p.wdata;
        else      pend.push_back('{port: eg1 ? 1 : 0, data: shadow[p.addr], due: cyc + 2});
      end
      if (!p1.req || eg1) starve = 0;
      else if (eg0 && starve < SMAX) starve++;
    end
    cyc++;
  endtask

  initial begin
    logic g0, g1;
    int   seq [10];
    int   exp_seq [10];
    preq_t p0, p1;
    exp_seq = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
    checks = 0; failures = 0; cyc = 0; starve = 0;
    exp_en = 1'b0; exp_we = 1'b0; exp_addr = '0; exp_wdata = '0;
    for (int i = 0; i < 256; i++) begin
      sram[i]   = W'(i * 7 + 3);
      shadow[i] = W'(i * 7 + 3);
    end
    sram[128] = 8'd6; shadow[128] = 8'd6;
    sram[129] = 8'd1; shadow[129] = 8'd1;

    rst = 1'b1;
    req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    repeat (2) @(posedge clk);

    // Reset holds grants low even with both requests up
    step(1'b1, rd(1), rd(2), g0, g1);
    step(1'b1, wr(3, 4), wr(5, 6), g0, g1);

    // Write then read of address 130 on port 0
    step(1'b0, wr(130, 8'h02), none(), g0, g1);
    step(1'b0, rd(130), none(), g0, g1);
    repeat (3) step(1'b0, none(), none(), g0, g1);

    // Contention: both requesting continuously
    for (int i = 0; i < 10; i++) begin
      step(1'b0, rd(i), wr(40 + i, i), g0, g1);
      seq[i] = g1 ? 1 : 0;
    end
    for (int i = 0; i < 10; i++) check($sformatf("contend_seq%0d", i), seq[i], exp_seq[i]);
    repeat (3) step(1'b0, none(), none(), g0, g1);

    // Port 1 alone, back-to-back reads
    step(1'b0, none(), rd(128), g0, g1);
    step(1'b0, none(), rd(129), g0, g1);
    repeat (3) step(1'b0, none(), none(), g0, g1);

    // Interleaved reads from both ports
    for (int i = 0; i < 8; i++) begin
      if (i % 2 == 0) step(1'b0, rd(40 + i), none(), g0, g1);
      else            step(1'b0, none(), rd(40 + i), g0, g1);
    end
    repeat (3) step(1'b0, none(), none(), g0, g1);

    // Reset one cycle after a read transfer; next request granted at once
    step(1'b0, rd(130), none(), g0, g1);
    step(1'b1, none(), none(), g0, g1);
    step(1'b0, none(), rd(128), g0, g1);
    check("post_rst_gnt1", g1, 1'b1);
    repeat (2) step(1'b0, none(), none(), g0, g1);

    // Idle bus for three cycles
    repeat (3) step(1'b0, none(), none(), g0, g1);

    // Randomized traffic with occasional resets
    for (int i = 0; i < 400; i++) begin
      p0 = ($urandom_range(0, 3) != 0) ?
           ($urandom_range(0, 1) != 0 ? wr($urandom_range(0, 31), $urandom) : rd($urandom_range(0, 31)))
           : none();
      p1 = ($urandom_range(0, 2) != 0) ?
           ($urandom_range(0, 1) != 0 ? wr($urandom_range(0, 31), $urandom) : rd($urandom_range(0, 31)))
           : none();
      step(($urandom_range(0, 49) == 0), p0, p1, g0, g1);
    end
    repeat (3) step(1'b0, none(), none(), g0, g1);
    check("pending_drained", pend.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Absolute time bound so the run always ends
  initial begin
    #200000;
    failures++;
    $display("FAIL timeout checks=%0d", checks);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
